// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: synchronises and deglitches clock/data, decodes 11-bit frames
// and queues good bytes in a show-ahead FIFO with parity/framing/overflow reporting.
module ps2_host_rx #(
   parameter int unsigned FILTER    = 4,
   parameter int unsigned TIMEOUT   = 2000,
   parameter int unsigned FIFO_BITS = 3
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd,
   input  logic       clr_ovf,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full,
   output logic       overflow,
   output logic       err_parity,
   output logic       err_frame,
   output logic       busy
);

   localparam int unsigned FW    = $clog2(FILTER + 1);
   localparam int unsigned TW    = $clog2(TIMEOUT + 1);
   localparam int unsigned DEPTH = 2 ** FIFO_BITS;
   localparam logic [FW-1:0] FiltLast = FW'(FILTER - 1);
   localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   logic [1:0]         clk_sync_q, data_sync_q;
   logic               clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
   logic [FW-1:0]      clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
   logic               clk_prev_q, fall_q, edge_q;
   state_e             state_q, state_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [7:0]         sh_q, sh_d;
   logic               par_q, par_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic               err_parity_q, err_parity_d, err_frame_q, err_frame_d;
   logic               ovf_q, ovf_d;
   logic [FIFO_BITS:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [7:0]         mem_q [DEPTH];
   logic               push, rd_en, wr_en;

   // Glitch filters: the filtered line only follows a synced value that persists FILTER cycles.
   always_comb begin
      clk_filt_d  = clk_filt_q;
      clk_cnt_d   = '0;
      data_filt_d = data_filt_q;
      data_cnt_d  = '0;
      if (clk_sync_q[1] != clk_filt_q) begin
         if (clk_cnt_q == FiltLast) clk_filt_d = ~clk_filt_q;
         else                       clk_cnt_d  = clk_cnt_q + 1'b1;
      end
      if (data_sync_q[1] != data_filt_q) begin
         if (data_cnt_q == FiltLast) data_filt_d = ~data_filt_q;
         else                        data_cnt_d  = data_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      sh_d         = sh_q;
      par_d        = par_q;
      tmo_d        = tmo_q;
      err_parity_d = 1'b0;
      err_frame_d  = 1'b0;
      push         = 1'b0;

      if (state_q == StIdle || edge_q) begin
         tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
         tmo_d       = '0;
         state_d     = StIdle;
         err_frame_d = 1'b1;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      if (fall_q) begin
         case (state_q)
            StIdle: begin
               if (!data_filt_q) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end
            end
            StData: begin
               sh_d      = {data_filt_q, sh_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = StParity;
            end
            StParity: begin
               par_d   = data_filt_q;
               state_d = StStop;
            end
            StStop: begin
               state_d = StIdle;
               if (!data_filt_q)          err_frame_d  = 1'b1;
               else if (!(^{sh_q, par_q})) err_parity_d = 1'b1;
               else                        push         = 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   always_comb begin
      rd_en  = rd & ~empty;
      wr_en  = push & (~full | rd_en);
      wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
      rptr_d = rd_en ? rptr_q + 1'b1 : rptr_q;
      ovf_d  = (ovf_q & ~clr_ovf) | (push & full & ~rd_en);
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         clk_sync_q   <= 2'b11;
         data_sync_q  <= 2'b11;
         clk_filt_q   <= 1'b1;
         data_filt_q  <= 1'b1;
         clk_cnt_q    <= '0;
         data_cnt_q   <= '0;
         clk_prev_q   <= 1'b1;
         fall_q       <= 1'b0;
         edge_q       <= 1'b0;
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         sh_q         <= '0;
         par_q        <= 1'b0;
         tmo_q        <= '0;
         err_parity_q <= 1'b0;
         err_frame_q  <= 1'b0;
         ovf_q        <= 1'b0;
         wptr_q       <= '0;
         rptr_q       <= '0;
      end else begin
         clk_sync_q   <= {clk_sync_q[0], ps2_clk};
         data_sync_q  <= {data_sync_q[0], ps2_data};
         clk_filt_q   <= clk_filt_d;
         data_filt_q  <= data_filt_d;
         clk_cnt_q    <= clk_cnt_d;
         data_cnt_q   <= data_cnt_d;
         clk_prev_q   <= clk_filt_q;
         fall_q       <= clk_prev_q & ~clk_filt_q;
         edge_q       <= clk_prev_q ^ clk_filt_q;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         sh_q         <= sh_d;
         par_q        <= par_d;
         tmo_q        <= tmo_d;
         err_parity_q <= err_parity_d;
         err_frame_q  <= err_frame_d;
         ovf_q        <= ovf_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (wr_en) mem_q[wptr_q[FIFO_BITS-1:0]] <= sh_q;
   end

   always_comb begin
      empty      = (wptr_q == rptr_q);
      full       = (wptr_q[FIFO_BITS] != rptr_q[FIFO_BITS]) &&
                   (wptr_q[FIFO_BITS-1:0] == rptr_q[FIFO_BITS-1:0]);
      dout       = empty ? 8'h00 : mem_q[rptr_q[FIFO_BITS-1:0]];
      overflow   = ovf_q;
      err_parity = err_parity_q;
      err_frame  = err_frame_q;
      busy       = (state_q != StIdle);
   end

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed and randomised PS/2 frames checked against a queue-based model of the receiver.
module tb_ps2_host_rx;

   localparam int unsigned FILTER    = 4;
   localparam int unsigned TIMEOUT   = 2000;
   localparam int unsigned FIFO_BITS = 3;
   localparam int unsigned DEPTH     = 8;

   logic       clk_sys  = 1'b0;
   logic       reset_n  = 1'b0;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd       = 1'b0;
   logic       clr_ovf  = 1'b0;
   logic [7:0] dout;
   logic       empty, full, overflow, err_parity, err_frame, busy;

   int         checks = 0;
   int         errors = 0;
   int         n_par = 0, n_frm = 0, exp_par = 0, exp_frm = 0;
   logic [7:0] q[$];
   logic       ovf_exp = 1'b0;

   ps2_host_rx #(
      .FILTER   (FILTER),
      .TIMEOUT  (TIMEOUT),
      .FIFO_BITS(FIFO_BITS)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd        (rd),
      .clr_ovf   (clr_ovf),
      .dout      (dout),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .err_parity(err_parity),
      .err_frame (err_frame),
      .busy      (busy)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (err_parity) n_par++;
      if (err_frame)  n_frm++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int hp);
      ps2_data = b;
      cyc(hp);
      ps2_clk = 1'b0;
      cyc(hp);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input int hp);
      send_bit(1'b0, hp);
      for (int i = 0; i < 8; i++) send_bit(d[i], hp);
      send_bit(par, hp);
      send_bit(stop, hp);
      ps2_data = 1'b1;
      cyc(hp);
   endtask

   // Frame outcome from the protocol rules alone.
   task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
      if (!stop)                 exp_frm++;
      else if (!(^d ^ par))      exp_par++;
      else if (q.size() == DEPTH) ovf_exp = 1'b1;
      else                       q.push_back(d);
   endtask

   task automatic check_state(input string tag);
      logic [7:0] head;
      head = (q.size() != 0) ? q[0] : 8'h00;
      check({tag, "_empty"}, empty, q.size() == 0);
      check({tag, "_full"}, full, q.size() == DEPTH);
      check({tag, "_dout"}, dout, head);
      check({tag, "_ovf"}, overflow, ovf_exp);
      check({tag, "_nparity"}, n_par, exp_par);
      check({tag, "_nframe"}, n_frm, exp_frm);
   endtask

   task automatic pop(input string tag);
      if (q.size() != 0) begin
         check({tag, "_head"}, dout, q[0]);
         rd = 1'b1;
         cyc(1);
         rd = 1'b0;
         void'(q.pop_front());
      end
   endtask

   initial begin
      int         lat;
      logic       seen_busy;
      logic [7:0] d;
      logic       par, stop;
      int         hp;

      // Reset state
      cyc(3);
      check("rst_busy", busy, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_dout", dout, 8'h00);
      check("rst_ovf", overflow, 1'b0);
      check("rst_errp", err_parity, 1'b0);
      check("rst_errf", err_frame, 1'b0);
      reset_n = 1'b1;
      cyc(2);

      // 0x1C with exact latency from the stop-bit falling edge
      send_bit(1'b0, 100);
      for (int i = 0; i < 8; i++) send_bit(((8'h1C >> i) & 8'h01) != 0, 100);
      send_bit(1'b0, 100);
      ps2_data = 1'b1;
      cyc(100);
      ps2_clk = 1'b0;
      cyc(7);
      check("t1_empty_at7", empty, 1'b1);
      cyc(1);
      check("t1_empty_at8", empty, 1'b0);
      check("t1_dout", dout, 8'h1C);
      cyc(92);
      ps2_clk = 1'b1;
      cyc(100);
      model_frame(8'h1C, 1'b0, 1'b1);
      check_state("t1");
      pop("t1");
      check_state("t1_read");

      // Bad parity, then a good 0xF0
      send_frame(8'h1C, 1'b1, 1'b1, 100);
      model_frame(8'h1C, 1'b1, 1'b1);
      check_state("t2_bad");
      send_frame(8'hF0, 1'b1, 1'b1, 100);
      model_frame(8'hF0, 1'b1, 1'b1);
      check_state("t2_good");
      pop("t2");

      // Stalled frame aborts after the timeout
      send_bit(1'b0, 100);
      send_bit(1'b1, 100);
      send_bit(1'b0, 100);
      send_bit(1'b1, 100);
      ps2_data = 1'b1;
      check("t3_busy_mid", busy, 1'b1);
      lat = 0;
      while (!err_frame && lat < 3000) begin
         cyc(1);
         lat++;
      end
      check("t3_tmo_window", (lat >= int'(TIMEOUT) - 1) && (lat <= int'(TIMEOUT + FILTER) + 6),
            1'b1);
      cyc(1);
      exp_frm++;
      check("t3_busy_after", busy, 1'b0);
      check_state("t3_tmo");
      send_frame(8'h5A, 1'b1, 1'b1, 100);
      model_frame(8'h5A, 1'b1, 1'b1);
      check_state("t3_5a");
      pop("t3");

      // Fill past capacity
      for (int i = 1; i <= 9; i++) begin
         d = 8'(i);
         send_frame(d, ~^d, 1'b1, 100);
         model_frame(d, ~^d, 1'b1);
         if (i == 8) check("t4_full8", full, 1'b1);
         if (i == 9) check("t4_ovf9", overflow, 1'b1);
      end
      check_state("t4_fill");
      while (q.size() != 0) pop("t4");
      check_state("t4_drained");
      clr_ovf = 1'b1;
      cyc(1);
      clr_ovf = 1'b0;
      ovf_exp = 1'b0;
      check("t4_clr_ovf", overflow, 1'b0);

      // Short clock glitch in idle is ignored
      ps2_data = 1'b0;
      cyc(10);
      ps2_clk = 1'b0;
      cyc(2);
      ps2_clk = 1'b1;
      seen_busy = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         seen_busy = seen_busy | busy;
      end
      ps2_data = 1'b1;
      cyc(20);
      check("t5_glitch_busy", seen_busy, 1'b0);
      check_state("t5_glitch");
      send_frame(8'h33, ~^8'h33, 1'b0, 100);
      model_frame(8'h33, ~^8'h33, 1'b0);
      check_state("t5_stop0");

      // Reset mid-frame, then a clean frame
      send_bit(1'b0, 100);
      for (int i = 0; i < 4; i++) send_bit(((8'hA7 >> i) & 8'h01) != 0, 100);
      reset_n = 1'b0;
      cyc(1);
      reset_n = 1'b1;
      q.delete();
      ovf_exp = 1'b0;
      check("t6_busy_rst", busy, 1'b0);
      cyc(50);
      send_frame(8'h2B, ~^8'h2B, 1'b1, 100);
      model_frame(8'h2B, ~^8'h2B, 1'b1);
      check_state("t6");
      pop("t6");
      check_state("t6_read");

      // Randomised frames with occasional corruption and random reads
      for (int n = 0; n < 12; n++) begin
         d    = 8'($urandom);
         par  = ~^d;
         stop = 1'b1;
         if ($urandom_range(0, 4) == 0) par = ~par;
         if ($urandom_range(0, 9) == 0) stop = 1'b0;
         hp = $urandom_range(10, 60);
         send_frame(d, par, stop, hp);
         model_frame(d, par, stop);
         check_state("rnd");
         for (int k = $urandom_range(0, 1); k > 0; k--) pop("rnd");
      end
      while (q.size() != 0) pop("rnd_drain");
      check_state("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
